// File: rtl/frame_sync.sv
// frame_sync: finds a sync word at any bit alignment in a stream of WS-bit words,
// locks to the frame, and re-emits the payload bit-aligned with a start-of-frame flag.

module frame_sync #(
  parameter int             WS          = 7,
  parameter int             SW          = 32,
  parameter logic [SW-1:0]  SYNC        = 32'h1acffc1d,
  parameter int             FRAME_WORDS = 256,
  parameter int             MISSES      = 3
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic [WS-1:0] i_word,
  output logic          o_valid,
  output logic [WS-1:0] o_word,
  output logic          o_sof,
  output logic          o_locked
);

  localparam int HW  = SW + 2*WS - 1;
  localparam int OW  = (WS > 1) ? $clog2(WS) : 1;
  localparam int WCW = $clog2(FRAME_WORDS + 1);
  localparam int MCW = $clog2(MISSES + 1);
  localparam int BCW = $clog2(SW + WS);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_PAYLOAD,
    ST_CHECK
  } state_t;

  state_t           state;
  logic [HW-WS-1:0] hist;
  logic [HW-1:0]    hist_next;
  logic [OW-1:0]    off;
  logic [WCW-1:0]   wcnt;
  logic [WCW-1:0]   wcnt_inc;
  logic [MCW-1:0]   mcnt;
  logic [MCW-1:0]   mcnt_inc;
  logic [BCW-1:0]   bit_cnt;
  logic [BCW-1:0]   bit_sum;
  logic             search_hit;
  logic [OW-1:0]    search_k;
  logic             check_done;
  logic             check_hit;
  logic [OW-1:0]    check_pos;

  assign hist_next = {hist, i_word};
  assign wcnt_inc  = wcnt + WCW'(1);
  assign mcnt_inc  = mcnt + MCW'(1);

  // Ascending scan so the last hit wins: the largest k is the earliest-ending sync.
  always_comb begin
    search_hit = 1'b0;
    search_k   = '0;
    for (int k = 0; k < WS; k++) begin
      if (hist_next[k +: SW] == SYNC) begin
        search_hit = 1'b1;
        search_k   = OW'(k);
      end
    end
  end

  // bit_cnt holds how many bits of the expected sync have already arrived.
  always_comb begin
    bit_sum    = bit_cnt + BCW'(WS);
    check_done = (bit_sum >= BCW'(SW));
    check_pos  = OW'(bit_sum - BCW'(SW));
    check_hit  = (hist_next[check_pos +: SW] == SYNC);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_SEARCH;
      hist     <= '0;
      off      <= '0;
      wcnt     <= '0;
      mcnt     <= '0;
      bit_cnt  <= '0;
      o_valid  <= 1'b0;
      o_word   <= '0;
      o_sof    <= 1'b0;
      o_locked <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_ce) begin
        hist  <= hist_next[HW-WS-1:0];
        o_sof <= 1'b0;
        case (state)
          ST_SEARCH: begin
            if (search_hit) begin
              off      <= search_k;
              wcnt     <= '0;
              mcnt     <= '0;
              o_locked <= 1'b1;
              state    <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            o_valid <= 1'b1;
            o_word  <= hist_next[off +: WS];
            o_sof   <= (wcnt == '0);
            wcnt    <= wcnt_inc;
            if (wcnt_inc == WCW'(FRAME_WORDS)) begin
              bit_cnt <= BCW'(off);
              state   <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (check_done) begin
              off  <= check_pos;
              wcnt <= '0;
              if (check_hit) begin
                mcnt  <= '0;
                state <= ST_PAYLOAD;
              end else if (mcnt_inc == MCW'(MISSES)) begin
                // Too many consecutive misses: drop lock and hunt again.
                mcnt     <= '0;
                off      <= '0;
                o_locked <= 1'b0;
                state    <= ST_SEARCH;
              end else begin
                mcnt  <= mcnt_inc;
                state <= ST_PAYLOAD;
              end
            end else begin
              bit_cnt <= bit_sum;
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

endmodule
